// File: rtl/updi_phy_rx.sv
// UPDI receive PHY: synchronises and oversamples the RX line, deserialises
// 12-bit frames (start, 8 data LSB first, even parity, 2 stops), flags SYNCH and BREAK.
`timescale 1ns/1ps
module updi_phy_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  input  logic        i_rx_en,
  output logic [7:0]  o_data,
  output logic [11:0] o_frame,
  output logic        o_valid,
  output logic        o_parity_err,
  output logic        o_frame_err,
  output logic        o_synch,
  output logic        o_break,
  output logic        o_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       SYNCH_CHAR = 8'h55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   rx_s;
  logic                   line_high_q;
  logic                   start_edge;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             par_q;
  logic             stop1_q;

  logic tick;
  logic abort;
  logic stop2_tick;
  logic is_break;
  logic frame_perr;
  logic frame_ferr;

  logic [7:0]  data_d;
  logic [11:0] frame_d;
  logic        perr_d;
  logic        ferr_d;
  logic        valid_d;
  logic        synch_d;
  logic        break_d;
  logic        busy_d;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // A start needs a high-to-low transition seen after the synchroniser has flushed,
  // so a line that is already low after reset or after a low stop bit is not a start.
  assign start_edge = line_high_q & ~rx_s;

  assign tick  = (state_q == S_START) ? (cnt_q == CNT_HALF) : (cnt_q == CNT_LAST);
  assign abort = ~i_rx_en & (state_q != S_IDLE);

  assign stop2_tick = (state_q == S_STOP2) & tick & ~abort;
  assign is_break   = (shreg_q == 8'h00) & ~par_q & ~stop1_q & ~rx_s;
  assign frame_perr = par_q ^ (^shreg_q);
  assign frame_ferr = ~stop1_q | ~rx_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (i_rx_en && start_edge) state_d = S_START;
        S_START:      if (tick) state_d = rx_s ? S_IDLE : S_DATA;
        S_DATA:       if (tick && (bit_cnt_q == 3'd7)) state_d = S_PARITY;
        S_PARITY:     if (tick) state_d = S_STOP1;
        S_STOP1:      if (tick) state_d = S_STOP2;
        S_STOP2:      if (tick) state_d = is_break ? S_BREAK_WAIT : S_IDLE;
        S_BREAK_WAIT: if (rx_s) state_d = S_IDLE;
        default:      state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: next values for the registered outputs; payload holds until next frame
  always_comb begin
    data_d  = o_data;
    frame_d = o_frame;
    perr_d  = o_parity_err;
    ferr_d  = o_frame_err;
    valid_d = 1'b0;
    synch_d = 1'b0;
    break_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    if (stop2_tick) begin
      if (is_break) begin
        break_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = shreg_q;
        frame_d = {1'b0, shreg_q, par_q, stop1_q, rx_s};
        perr_d  = frame_perr;
        ferr_d  = frame_ferr;
        synch_d = (shreg_q == SYNCH_CHAR) & ~frame_perr & ~frame_ferr;
      end
    end
  end

  // Synchroniser, sample/bit counters, shift register and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '1;
      fill_q       <= '0;
      line_high_q  <= 1'b0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      stop1_q      <= 1'b0;
      o_data       <= '0;
      o_frame      <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_synch      <= 1'b0;
      o_break      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], i_rx};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      line_high_q <= fill_q[SYNC_STAGES-1] & rx_s;

      if ((state_q == S_IDLE) || (state_q == S_BREAK_WAIT) || tick || abort) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (state_q == S_START) begin
        bit_cnt_q <= '0;
      end else if ((state_q == S_DATA) && tick) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end

      if ((state_q == S_DATA) && tick) begin
        shreg_q <= {rx_s, shreg_q[7:1]};
      end
      if ((state_q == S_PARITY) && tick) begin
        par_q <= rx_s;
      end
      if ((state_q == S_STOP1) && tick) begin
        stop1_q <= rx_s;
      end

      o_data       <= data_d;
      o_frame      <= frame_d;
      o_valid      <= valid_d;
      o_parity_err <= perr_d;
      o_frame_err  <= ferr_d;
      o_synch      <= synch_d;
      o_break      <= break_d;
      o_busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_updi_phy_rx.sv
// Bench for updi_phy_rx: directed frames on i_rx, expected responses queued and
// checked by an independent monitor whenever o_valid fires.
`timescale 1ns/1ps
module tb_updi_phy_rx;

  localparam int BIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx;
  logic        i_rx_en;
  logic [7:0]  o_data;
  logic [11:0] o_frame;
  logic        o_valid;
  logic        o_parity_err;
  logic        o_frame_err;
  logic        o_synch;
  logic        o_break;
  logic        o_busy;

  updi_phy_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .i_rx_en      (i_rx_en),
    .o_data       (o_data),
    .o_frame      (o_frame),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_synch      (o_synch),
    .o_break      (o_break),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    logic        perr;
    logic        ferr;
    logic        synch;
    logic        chk_lat;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_fall = 0;
  int valid_cnt = 0;
  int break_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Line stays at b for n falling clock edges
  task automatic bit_out(input logic b, input int n);
    i_rx = b;
    repeat (n) @(negedge clk);
  endtask

  // Drive the first nbits of a frame in line order: start, d0..d7, parity, stop1, stop2
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                            input logic s2, input int nbits);
    logic [11:0] bits;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[9]  = p;
    bits[10] = s1;
    bits[11] = s2;
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) t_fall = cyc;
      bit_out(bits[k], BIT);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input logic lat);
    exp_t e;
    e.data    = d;
    e.frame   = {1'b0, d, p, s1, s2};
    e.perr    = p ^ (^d);
    e.ferr    = ~(s1 & s2);
    e.synch   = (d == 8'h55) && (p == ^d) && s1 && s2;
    e.chk_lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation on every o_valid
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(posedge clk);
      #1;
      if (o_break) break_cnt++;
      if (o_synch) check("synch_needs_valid", 32'(o_valid), 32'd1);
      if (o_valid) begin
        valid_cnt++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got data 0x%0h, expected no frame", o_data);
        end else begin
          e = sb.pop_front();
          check("data",  32'(o_data),       32'(e.data));
          check("frame", 32'(o_frame),      32'(e.frame));
          check("perr",  32'(o_parity_err), 32'(e.perr));
          check("ferr",  32'(o_frame_err),  32'(e.ferr));
          check("synch", 32'(o_synch),      32'(e.synch));
          if (e.chk_lat) begin
            lat = cyc - t_fall;
            n_vec++;
            if (lat < 186 || lat > 188) begin
              n_err++;
              $display("FAIL latency: got %0d cycles expected 186..188", lat);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_rx = 1'b1;
    i_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_frame", 32'(o_frame), 32'd0);
    check("rst_flags", 32'({o_valid, o_parity_err, o_frame_err, o_synch, o_break, o_busy}), 32'd0);
    rst = 1'b0;
    bit_out(1'b1, 40);

    // SYNCH character with latency measurement
    expect_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 12);
    bit_out(1'b1, 32);

    // Wrong parity
    expect_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 12);
    bit_out(1'b1, 32);

    // stop2 low, then next frame inside the same 12-bit slot boundary
    expect_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 11);
    bit_out(1'b0, 12);
    bit_out(1'b1, 4);
    expect_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 12);
    bit_out(1'b1, 32);
    check("valid_cnt_frames", 32'(valid_cnt), 32'd4);

    // BREAK: line low for 30 bit periods
    bit_out(1'b0, 30 * BIT);
    check("break_once", 32'(break_cnt), 32'd1);
    check("busy_in_break", 32'(o_busy), 32'd1);
    bit_out(1'b1, 32);
    check("no_valid_in_break", 32'(valid_cnt), 32'd4);
    expect_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 12);
    bit_out(1'b1, 32);

    // Short glitch on idle line
    bit_out(1'b0, 5);
    bit_out(1'b1, 40);
    check("glitch_no_valid", 32'(valid_cnt), 32'd5);
    check("glitch_idle", 32'(o_busy), 32'd0);

    // Reset during data bit 3
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 4);
    bit_out(1'b1, 8);
    check("busy_before_rst", 32'(o_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data",  32'(o_data),  32'd0);
    check("midrst_frame", 32'(o_frame), 32'd0);
    check("midrst_flags", 32'({o_valid, o_parity_err, o_frame_err, o_synch, o_break, o_busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bit_out(1'b1, 48);
    expect_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 12);
    bit_out(1'b1, 32);

    // Enable dropped during parity, then a whole frame while disabled
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 9);
    i_rx = 1'b0;
    repeat (6) @(negedge clk);
    i_rx_en = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", 32'(o_busy), 32'd0);
    bit_out(1'b0, 8);
    bit_out(1'b1, 2 * BIT + 16);
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 12);
    bit_out(1'b1, 16);
    i_rx_en = 1'b1;
    bit_out(1'b1, 40);
    check("held_data",  32'(o_data),  32'h3C);
    check("held_frame", 32'(o_frame), 32'(12'b0_00111100_0_11));
    check("total_valid", 32'(valid_cnt), 32'd6);
    check("total_break", 32'(break_cnt), 32'd1);
    check("sb_drained",  32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
